dm_arbiter: RTL and testbench

//  Shares the single-port 256-word data memory (DM) between two requesters:

---
 rtl/dm_arbiter.sv | 123 ++++++++++++
 tb/tb_dm_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU MEM stage (A) versus loader/DMA (B).
// A has priority; B gets a starvation guard and a bounded lock mode for bursts.
module dm_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout,
  output logic              addr_err,
  output logic              cpu_stall
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  owner_t        owner_reg, owner_next;
  logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
  logic [LW-1:0] lock_cnt_reg, lock_cnt_next;
  logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;
  logic          a_rvalid_reg, b_rvalid_reg, addr_err_reg;

  logic rule_lock, rule_starve;
  logic a_oor, b_oor;

  assign a_oor = |a_addr[31:ADDR_W];
  assign b_oor = |b_addr[31:ADDR_W];

  assign rule_lock   = (owner_reg == OWN_B) & b_lock & b_req & (lock_cnt_reg < LW'(LOCK_MAX));
  assign rule_starve = b_req & (starve_cnt_reg == SW'(STARVE_MAX));

  // Grants are gated by reset so nothing reaches the DM while reset is held low.
  assign b_gnt     = reset & (rule_lock | rule_starve | (b_req & ~a_req));
  assign a_gnt     = reset & a_req & ~rule_lock & ~rule_starve;
  assign cpu_stall = a_req & ~a_gnt;

  always_comb begin
    owner_next      = OWN_NONE;
    lock_cnt_next   = '0;
    starve_cnt_next = '0;
    if (b_gnt) begin
      owner_next    = OWN_B;
      lock_cnt_next = rule_lock ? lock_cnt_reg + 1'b1 : LW'(1);
    end else if (a_gnt) begin
      owner_next = OWN_A;
    end
    if (b_req && !b_gnt) begin
      starve_cnt_next = (starve_cnt_reg == SW'(STARVE_MAX)) ? starve_cnt_reg
                                                            : starve_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    if (a_gnt) begin
      dm_we   = a_we & ~a_oor;
      dm_addr = {{(32-ADDR_W){1'b0}}, a_addr[ADDR_W-1:0]};
      dm_din  = a_wdata;
    end else if (b_gnt) begin
      dm_we   = b_we & ~b_oor;
      dm_addr = {{(32-ADDR_W){1'b0}}, b_addr[ADDR_W-1:0]};
      dm_din  = b_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
      lock_cnt_reg   <= '0;
      a_rdata_reg    <= '0;
      b_rdata_reg    <= '0;
      a_rvalid_reg   <= 1'b0;
      b_rvalid_reg   <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
      lock_cnt_reg   <= lock_cnt_next;
      a_rvalid_reg   <= a_gnt & ~a_we;
      b_rvalid_reg   <= b_gnt & ~b_we;
      addr_err_reg   <= (a_gnt & a_oor) | (b_gnt & b_oor);
      // Out-of-range reads return zero rather than whatever the truncated address hits.
      if (a_gnt && !a_we) a_rdata_reg <= a_oor ? '0 : dm_dout;
      if (b_gnt && !b_we) b_rdata_reg <= b_oor ? '0 : dm_dout;
    end
  end

  assign a_rdata  = a_rdata_reg;
  assign b_rdata  = b_rdata_reg;
  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 256-word DM and a read/addr_err scoreboard.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we, b_lock;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, dm_we, addr_err, cpu_stall;
  logic [31:0] a_rdata, b_rdata, dm_addr, dm_din, dm_dout;

  logic [31:0] mem [0:255];
  logic        mem_init;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int          exp_err[$];

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_lock(b_lock),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
    .addr_err(addr_err), .cpu_stall(cpu_stall)
  );

  // DM model: synchronous write, combinational read; preloaded with 0x1000+i, DM[5]=0xCAFE.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000 + i;
      mem[5] <= 32'h0000_CAFE;
    end else if (dm_we) begin
      mem[dm_addr[7:0]] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr[7:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step(input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                      input logic br, input logic bw, input logic bl,
                      input logic [31:0] ba, input logic [31:0] bd);
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (a_rvalid) begin
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL a_rvalid_unexpected: got rvalid=1 rdata=%h expected none", a_rdata);
        end else begin
          e = exp_a.pop_front();
          chk("a_rdata", a_rdata, e);
        end
      end
      if (b_rvalid) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL b_rvalid_unexpected: got rvalid=1 rdata=%h expected none", b_rdata);
        end else begin
          e = exp_b.pop_front();
          chk("b_rdata", b_rdata, e);
        end
      end
      if (addr_err) begin
        if (exp_err.size() == 0) begin
          total++; bad++;
          $display("FAIL addr_err_unexpected: got 1 expected 0");
        end else begin
          void'(exp_err.pop_front());
          chk("addr_err", {31'd0, addr_err}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_bg, exp_ag, ar;
    reset = 1'b0; mem_init = 1'b1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd7; a_wdata = 32'hDEAD;
    b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = 32'd0; b_wdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    mem_init = 1'b0; reset = 1'b1; a_req = 1'b0; a_we = 1'b0;

    // T1: single A read of DM[5]
    step(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t1_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t1_dm_addr", dm_addr, 32'd5);
    chk("t1_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    exp_a.push_back(32'h0000_CAFE);
    idle();

    // T2: both requesting; B forced in cycle 5, A back in cycle 6
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
      exp_bg = (c == 5);
      chk($sformatf("t2_b_gnt_c%0d", c), {31'd0, b_gnt}, {31'd0, exp_bg});
      chk($sformatf("t2_a_gnt_c%0d", c), {31'd0, a_gnt}, {31'd0, ~exp_bg});
      if (exp_bg) begin
        chk("t2_cpu_stall", {31'd0, cpu_stall}, 32'd1);
        exp_b.push_back(32'h1002);
      end else begin
        exp_a.push_back(32'h1001);
      end
    end
    idle();

    // T3a: locked B burst, A requesting from cycle 2 -> B cycles 1-8, A afterwards
    for (int c = 1; c <= 12; c++) begin
      ar = (c >= 2);
      step(ar, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0);
      exp_bg = (c <= 8);
      exp_ag = ar & ~exp_bg;
      chk($sformatf("t3a_b_gnt_c%0d", c), {31'd0, b_gnt}, {31'd0, exp_bg});
      chk($sformatf("t3a_a_gnt_c%0d", c), {31'd0, a_gnt}, {31'd0, exp_ag});
      if (exp_bg) exp_b.push_back(32'h1003);
      if (exp_ag) exp_a.push_back(32'h1004);
    end
    idle();

    // T3b: locked B burst without A -> B holds all 12 cycles
    for (int c = 1; c <= 12; c++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0);
      chk($sformatf("t3b_b_gnt_c%0d", c), {31'd0, b_gnt}, 32'd1);
      exp_b.push_back(32'h1003);
    end
    idle();

    // T4: out-of-range B write then read of addr 300 (aliases DM[44])
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd300, 32'h1234);
    chk("t4_b_gnt", {31'd0, b_gnt}, 32'd1);
    chk("t4_dm_we", {31'd0, dm_we}, 32'd0);
    exp_err.push_back(1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd300, 32'd0);
    exp_b.push_back(32'd0);
    exp_err.push_back(1);
    idle();
    chk("t4_dm44_unchanged", mem[44], 32'h102C);

    // T5: A write then read-after-write of addr 9
    step(1'b1, 1'b1, 32'd9, 32'hBEEF, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("t5_dm_we", {31'd0, dm_we}, 32'd1);
    chk("t5_dm_din", dm_din, 32'hBEEF);
    step(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    exp_a.push_back(32'hBEEF);

    // Same-address collision: only A's write lands
    step(1'b1, 1'b1, 32'd10, 32'hAAAA, 1'b1, 1'b1, 1'b0, 32'd10, 32'hBBBB);
    chk("col_dm_din", dm_din, 32'hAAAA);
    idle();
    chk("col_dm10", mem[10], 32'hAAAA);

    // T6: reset during a granted locked B write
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd20, 32'h5555);
    chk("t6_pre_dm_we", {31'd0, dm_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("t6_rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
    #1;
    chk("t6_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    chk("t6_addr_err", {31'd0, addr_err}, 32'd0);
    chk("t6_lock_cnt", 32'(dut.lock_cnt_reg), 32'd0);
    chk("t6_starve_cnt", 32'(dut.starve_cnt_reg), 32'd0);
    chk("t6_dm20", mem[20], 32'h1014);
    // Ownership lost: a fresh locked B request does not beat A
    step(1'b1, 1'b0, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd0);
    chk("t6_a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("t6_b_gnt", {31'd0, b_gnt}, 32'd0);
    exp_a.push_back(32'h1004);
    idle();
    idle();
    chk("hold_a_rdata", a_rdata, 32'h1004);
    chk("sb_a_empty", exp_a.size(), 32'd0);
    chk("sb_b_empty", exp_b.size(), 32'd0);
    chk("sb_err_empty", exp_err.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
